dc_pipe: RTL and testbench

- Registered, handshaked RV32I decode stage with a 2-entry decoded-result buffer.
- Sits between the instruction queue (first-word-fall-through) and register file / reservation-station dispatch.
- Successor to the combinational decoder: parametrised widths, full sign-extended immediates, correct branch/store/shift decode, illegal-instruction flag, source-use flags, back-pressure and flush.

---
 rtl/dc_pipe_if.sv | 53 +++++
 rtl/dc_pipe.sv | 255 +++++++++++++++++++++++++
 tb/tb_dc_pipe.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dc_pipe_if.sv
// dc_pipe_if: bundles the instruction-queue side and the dispatch side of the
// decode stage.
//
// Handshakes:
//   queue side    - the queue is first-word-fall-through. pc/instr are valid
//                   whenever is_empty_from_instr_queue is 0. The head is
//                   consumed at the clock edge when pop_to_instr_queue is 1.
//   dispatch side - valid/ready. The entry on *_to_reg transfers at the clock
//                   edge when valid_to_reg && ready_from_dispatch. While
//                   valid && !ready the outputs hold stable.
//
// Modports:
//   master - the decode stage (dc_pipe)
//   slave  - the environment (instruction queue + dispatch)
interface dc_pipe_if #(
    parameter int PcWidth     = 32,
    parameter int InstrWidth  = 32,
    parameter int RegIdxWidth = 5,
    parameter int DataWidth   = 32,
    parameter int OpWidth     = 6
);
    logic                   is_empty_from_instr_queue;
    logic [PcWidth-1:0]     pc_from_instr_queue;
    logic [InstrWidth-1:0]  instr_from_instr_queue;
    logic                   pop_to_instr_queue;
    logic                   ready_from_dispatch;
    logic                   valid_to_reg;
    logic [PcWidth-1:0]     pc_to_reg;
    logic [OpWidth-1:0]     op_to_reg;
    logic [RegIdxWidth-1:0] rd_to_reg;
    logic [RegIdxWidth-1:0] rs1_to_reg;
    logic [RegIdxWidth-1:0] rs2_to_reg;
    logic                   use_rs1_to_reg;
    logic                   use_rs2_to_reg;
    logic [DataWidth-1:0]   imm_to_reg;
    logic                   illegal_to_reg;

    modport master (
        input  is_empty_from_instr_queue, pc_from_instr_queue,
               instr_from_instr_queue, ready_from_dispatch,
        output pop_to_instr_queue, valid_to_reg, pc_to_reg, op_to_reg,
               rd_to_reg, rs1_to_reg, rs2_to_reg, use_rs1_to_reg,
               use_rs2_to_reg, imm_to_reg, illegal_to_reg
    );

    modport slave (
        output is_empty_from_instr_queue, pc_from_instr_queue,
               instr_from_instr_queue, ready_from_dispatch,
        input  pop_to_instr_queue, valid_to_reg, pc_to_reg, op_to_reg,
               rd_to_reg, rs1_to_reg, rs2_to_reg, use_rs1_to_reg,
               use_rs2_to_reg, imm_to_reg, illegal_to_reg
    );
endinterface

// File: rtl/dc_pipe.sv
// dc_pipe: registered RV32I decode stage with a 2-entry decoded-result FIFO.
//
// The queue head is decoded combinationally. When it is popped, the decoded
// result is written into the buffer at that clock edge. The oldest buffered
// entry drives the dispatch outputs.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset; clears the buffer and all outputs
//   clr  - synchronous flush; empties the buffer, blocks pop and transfer
//   bus  - dc_pipe_if.master (queue-side pop handshake, dispatch-side
//          valid/ready)
module dc_pipe #(
    parameter int PcWidth     = 32,
    parameter int InstrWidth  = 32,
    parameter int RegIdxWidth = 5,
    parameter int DataWidth   = 32,
    parameter int OpWidth     = 6
) (
    input logic        clk,
    input logic        rst,
    input logic        clr,
    dc_pipe_if.master  bus
);

    typedef struct packed {
        logic [PcWidth-1:0]     pc;
        logic [OpWidth-1:0]     op;
        logic [RegIdxWidth-1:0] rd;
        logic [RegIdxWidth-1:0] rs1;
        logic [RegIdxWidth-1:0] rs2;
        logic                   use_rs1;
        logic                   use_rs2;
        logic [DataWidth-1:0]   imm;
        logic                   illegal;
    } entry_t;

    // ------------------------------------------------------------------
    // Decode of the queue head
    // ------------------------------------------------------------------
    logic [31:0] ins;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] i_imm;

    assign ins   = bus.instr_from_instr_queue;
    assign opc   = ins[6:0];
    assign f3    = ins[14:12];
    assign f7    = ins[31:25];
    assign i_imm = {{20{ins[31]}}, ins[31:20]};

    logic [5:0]  op_n;
    logic        ill;
    logic        use_rd;
    logic        use_r1;
    logic        use_r2;
    logic [31:0] imm32;

    always_comb begin
        op_n   = '0;
        ill    = 1'b0;
        use_rd = 1'b0;
        use_r1 = 1'b0;
        use_r2 = 1'b0;
        imm32  = '0;
        case (opc)
            7'b0110111: begin  // LUI
                op_n   = 6'd1;
                use_rd = 1'b1;
                imm32  = {ins[31:12], 12'b0};
            end
            7'b0010111: begin  // AUIPC
                op_n   = 6'd2;
                use_rd = 1'b1;
                imm32  = {ins[31:12], 12'b0};
            end
            7'b1101111: begin  // JAL
                op_n   = 6'd3;
                use_rd = 1'b1;
                imm32  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'b1100111: begin  // JALR
                op_n   = 6'd4;
                use_rd = 1'b1;
                use_r1 = 1'b1;
                imm32  = i_imm;
                ill    = (f3 != 3'b000);
            end
            7'b1100011: begin  // branches
                use_r1 = 1'b1;
                use_r2 = 1'b1;
                imm32  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
                case (f3)
                    3'b000:  op_n = 6'd5;
                    3'b001:  op_n = 6'd6;
                    3'b100:  op_n = 6'd7;
                    3'b101:  op_n = 6'd8;
                    3'b110:  op_n = 6'd9;
                    3'b111:  op_n = 6'd10;
                    default: ill  = 1'b1;
                endcase
            end
            7'b0000011: begin  // loads
                use_rd = 1'b1;
                use_r1 = 1'b1;
                imm32  = i_imm;
                case (f3)
                    3'b000:  op_n = 6'd11;
                    3'b001:  op_n = 6'd12;
                    3'b010:  op_n = 6'd13;
                    3'b100:  op_n = 6'd14;
                    3'b101:  op_n = 6'd15;
                    default: ill  = 1'b1;
                endcase
            end
            7'b0100011: begin  // stores
                use_r1 = 1'b1;
                use_r2 = 1'b1;
                imm32  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                case (f3)
                    3'b000:  op_n = 6'd16;
                    3'b001:  op_n = 6'd17;
                    3'b010:  op_n = 6'd18;
                    default: ill  = 1'b1;
                endcase
            end
            7'b0010011: begin  // register-immediate ALU
                use_rd = 1'b1;
                use_r1 = 1'b1;
                imm32  = i_imm;
                case (f3)
                    3'b000: op_n = 6'd19;
                    3'b010: op_n = 6'd20;
                    3'b011: op_n = 6'd21;
                    3'b100: op_n = 6'd22;
                    3'b110: op_n = 6'd23;
                    3'b111: op_n = 6'd24;
                    3'b001: begin
                        // Shifts take a zero-extended shamt. The exact funct7
                        // match also rejects instr[25]=1 (64-bit shamt).
                        op_n  = 6'd25;
                        imm32 = {27'b0, ins[24:20]};
                        ill   = (f7 != 7'b0000000);
                    end
                    default: begin  // 3'b101: SRLI / SRAI
                        imm32 = {27'b0, ins[24:20]};
                        if (f7 == 7'b0000000)      op_n = 6'd26;
                        else if (f7 == 7'b0100000) op_n = 6'd27;
                        else                       ill  = 1'b1;
                    end
                endcase
            end
            7'b0110011: begin  // register-register ALU
                use_rd = 1'b1;
                use_r1 = 1'b1;
                use_r2 = 1'b1;
                case ({f7, f3})
                    {7'b0000000, 3'b000}: op_n = 6'd28;
                    {7'b0100000, 3'b000}: op_n = 6'd29;
                    {7'b0000000, 3'b001}: op_n = 6'd30;
                    {7'b0000000, 3'b010}: op_n = 6'd31;
                    {7'b0000000, 3'b011}: op_n = 6'd32;
                    {7'b0000000, 3'b100}: op_n = 6'd33;
                    {7'b0000000, 3'b101}: op_n = 6'd34;
                    {7'b0100000, 3'b101}: op_n = 6'd35;
                    {7'b0000000, 3'b110}: op_n = 6'd36;
                    {7'b0000000, 3'b111}: op_n = 6'd37;
                    default:              ill  = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        // An illegal instruction still flows downstream, carrying only its pc.
        if (ill) begin
            op_n   = '0;
            use_rd = 1'b0;
            use_r1 = 1'b0;
            use_r2 = 1'b0;
            imm32  = '0;
        end
    end

    entry_t dec;

    always_comb begin
        dec         = '0;
        dec.pc      = bus.pc_from_instr_queue;
        dec.op      = OpWidth'(op_n);
        dec.rd      = use_rd ? RegIdxWidth'(ins[11:7])  : '0;
        dec.rs1     = use_r1 ? RegIdxWidth'(ins[19:15]) : '0;
        dec.rs2     = use_r2 ? RegIdxWidth'(ins[24:20]) : '0;
        dec.use_rs1 = use_r1;
        dec.use_rs2 = use_r2;
        dec.imm     = DataWidth'($signed(imm32));
        dec.illegal = ill;
    end

    // ------------------------------------------------------------------
    // 2-entry result FIFO
    // ------------------------------------------------------------------
    entry_t     mem [2];
    logic [1:0] count;
    logic       head;
    logic       tail;
    logic       valid;
    logic       pop;
    logic       xfer;

    assign valid = (count != 2'd0);
    // When full, a pop is allowed only if the head leaves in the same cycle.
    // rst is included so that pop drops as soon as reset asserts.
    assign pop   = rst && !bus.is_empty_from_instr_queue && !clr &&
                   ((count != 2'd2) || bus.ready_from_dispatch);
    assign xfer  = valid && bus.ready_from_dispatch && !clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (clr) begin
            count <= '0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            // When full with a simultaneous transfer, tail == head. The old
            // head is read out this cycle while its slot is overwritten.
            if (pop) begin
                mem[tail] <= dec;
                tail      <= ~tail;
            end
            if (xfer) head <= ~head;
            count <= count + {1'b0, pop} - {1'b0, xfer};
        end
    end

    entry_t out_e;
    assign out_e = valid ? mem[head] : '0;

    assign bus.pop_to_instr_queue = pop;
    assign bus.valid_to_reg       = valid;
    assign bus.pc_to_reg          = out_e.pc;
    assign bus.op_to_reg          = out_e.op;
    assign bus.rd_to_reg          = out_e.rd;
    assign bus.rs1_to_reg         = out_e.rs1;
    assign bus.rs2_to_reg         = out_e.rs2;
    assign bus.use_rs1_to_reg     = out_e.use_rs1;
    assign bus.use_rs2_to_reg     = out_e.use_rs2;
    assign bus.imm_to_reg         = out_e.imm;
    assign bus.illegal_to_reg     = out_e.illegal;

endmodule

// File: tb/tb_dc_pipe.sv
module tb_dc_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic clr;
    always #5 clk = ~clk;

    dc_pipe_if bus ();

    dc_pipe dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    int pop_count;
    logic [87:0] exp_q[$];

    // Instruction patterns in op-code order: op = index + 1.
    // fmt: 0=U 1=J 2=I 3=B 4=S 5=shift-imm 6=R
    logic [31:0] pmask  [37];
    logic [31:0] pmatch [37];
    int          pfmt   [37];

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [31:0] imm;
        logic        ill;
    } vec_t;
    vec_t vt[$];

    task automatic add_vec(input logic [31:0] i, input int op, rd, rs1, rs2,
                           input bit u1, u2, input logic [31:0] imm, input bit ill);
        vec_t v;
        v.instr = i; v.op = 6'(op); v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
        v.u1 = u1; v.u2 = u2; v.imm = imm; v.ill = ill;
        vt.push_back(v);
    endtask

    task automatic init_patterns();
        pmatch = '{32'h37, 32'h17, 32'h6F, 32'h67,
                   32'h63, 32'h1063, 32'h4063, 32'h5063, 32'h6063, 32'h7063,
                   32'h03, 32'h1003, 32'h2003, 32'h4003, 32'h5003,
                   32'h23, 32'h1023, 32'h2023,
                   32'h13, 32'h2013, 32'h3013, 32'h4013, 32'h6013, 32'h7013,
                   32'h1013, 32'h5013, 32'h40005013,
                   32'h33, 32'h40000033, 32'h1033, 32'h2033, 32'h3033,
                   32'h4033, 32'h5033, 32'h40005033, 32'h6033, 32'h7033};
        for (int k = 0; k < 37; k++) begin
            pmask[k] = (k < 3) ? 32'h7F : (k < 24) ? 32'h707F : 32'hFE00707F;
            if (k < 2)       pfmt[k] = 0;
            else if (k == 2) pfmt[k] = 1;
            else if (k == 3) pfmt[k] = 2;
            else if (k < 10) pfmt[k] = 3;
            else if (k < 15) pfmt[k] = 2;
            else if (k < 18) pfmt[k] = 4;
            else if (k < 24) pfmt[k] = 2;
            else if (k < 27) pfmt[k] = 5;
            else             pfmt[k] = 6;
        end
    endtask

    // Reference decode: pattern lookup plus arithmetic immediates.
    function automatic logic [87:0] ref_decode(input logic [31:0] pc, input logic [31:0] ins);
        int found = -1;
        int fmt;
        int v;
        logic [4:0] rd, rs1, rs2;
        bit u1, u2;
        for (int k = 0; k < 37; k++)
            if (found < 0 && ((ins & pmask[k]) == pmatch[k])) found = k;
        if (found < 0) return {pc, 6'd0, 15'd0, 2'b00, 32'd0, 1'b1};
        fmt = pfmt[found];
        u1  = (fmt != 0) && (fmt != 1);
        u2  = (fmt == 3) || (fmt == 4) || (fmt == 6);
        rd  = (fmt == 3 || fmt == 4) ? 5'd0 : ins[11:7];
        rs1 = u1 ? ins[19:15] : 5'd0;
        rs2 = u2 ? ins[24:20] : 5'd0;
        case (fmt)
            0: v = int'(ins & 32'hFFFFF000);
            1: v = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 +
                   int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            2: v = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
            3: v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 +
                   int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            4: v = (ins[31] ? -2048 : 0) + int'(ins[30:25]) * 32 + int'(ins[11:7]);
            5: v = int'(ins[24:20]);
            default: v = 0;
        endcase
        return {pc, 6'(found + 1), rd, rs1, rs2, u1, u2, 32'(v), 1'b0};
    endfunction

    function automatic logic [87:0] dut_out();
        return {bus.pc_to_reg, bus.op_to_reg, bus.rd_to_reg, bus.rs1_to_reg,
                bus.rs2_to_reg, bus.use_rs1_to_reg, bus.use_rs2_to_reg,
                bus.imm_to_reg, bus.illegal_to_reg};
    endfunction

    task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("valid", 88'(bus.valid_to_reg), 88'(exp_q.size() > 0));
        if (exp_q.size() > 0) check("entry", dut_out(), exp_q[0]);
        else                  check("idle_out", dut_out(), 88'd0);
    endtask

    // ---------------- driver: one cycle, starting and ending at negedge ----------------
    task automatic cycle(input bit e, input logic [31:0] p, input logic [31:0] i,
                         input bit r, input bit c);
        bit exp_pop;
        check_outputs();
        bus.is_empty_from_instr_queue = e;
        bus.pc_from_instr_queue       = p;
        bus.instr_from_instr_queue    = i;
        bus.ready_from_dispatch       = r;
        clr                           = c;
        #1;
        exp_pop = !e && !c && (exp_q.size() < 2 || r);
        check("pop", 88'(bus.pop_to_instr_queue), 88'(exp_pop));
        if (bus.pop_to_instr_queue) pop_count++;
        @(posedge clk);
        if (c) exp_q.delete();
        else begin
            if (exp_q.size() > 0 && r) void'(exp_q.pop_front());
            if (exp_pop) exp_q.push_back(ref_decode(p, i));
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        int k;
        if ($urandom_range(0, 3) == 0) return $urandom;
        k = $urandom_range(0, 36);
        return pmatch[k] | ($urandom & ~pmask[k]);
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] pc;
        init_patterns();
        add_vec(32'h00500093, 19, 1, 0, 0, 1, 0, 32'h5,        0);
        add_vec(32'hFE0008E3,  5, 0, 0, 0, 1, 1, 32'hFFFFFFF0, 0);
        add_vec(32'h40208033, 29, 0, 1, 2, 1, 1, 32'h0,        0);
        add_vec(32'h0000007F,  0, 0, 0, 0, 0, 0, 32'h0,        1);
        add_vec(32'h0200D093,  0, 0, 0, 0, 0, 0, 32'h0,        1);
        add_vec(32'h123452B7,  1, 5, 0, 0, 0, 0, 32'h12345000, 0);
        add_vec(32'hFFDFF0EF,  3, 1, 0, 0, 0, 0, 32'hFFFFFFFC, 0);
        add_vec(32'hFE21AC23, 18, 0, 3, 2, 1, 1, 32'hFFFFFFF8, 0);
        add_vec(32'h4032D213, 27, 4, 5, 0, 1, 0, 32'h3,        0);
        add_vec(32'h02109093,  0, 0, 0, 0, 0, 0, 32'h0,        1);
        add_vec(32'h7FF45383, 15, 7, 8, 0, 1, 0, 32'h7FF,      0);
        add_vec(32'h00002063,  0, 0, 0, 0, 0, 0, 32'h0,        1);
        add_vec(32'hFFFFF517,  2, 10, 0, 0, 0, 0, 32'hFFFFF000, 0);
        add_vec(32'h005271B3, 37, 3, 4, 5, 1, 1, 32'h0,        0);

        // Reset with a non-empty queue: no pop, everything zero.
        rst = 1'b0;
        clr = 1'b0;
        bus.is_empty_from_instr_queue = 1'b0;
        bus.pc_from_instr_queue       = 32'h100;
        bus.instr_from_instr_queue    = 32'h00500093;
        bus.ready_from_dispatch       = 1'b1;
        #1;
        check("rst_pop", 88'(bus.pop_to_instr_queue), 88'd0);
        check("rst_valid", 88'(bus.valid_to_reg), 88'd0);
        check("rst_out", dut_out(), 88'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Table vectors: each one is popped alone and checked on the next cycle.
        for (int k = 0; k < vt.size(); k++) begin
            pc = 32'h100 + 32'(k * 4);
            cycle(1'b0, pc, vt[k].instr, 1'b1, 1'b0);
            check($sformatf("vec%0d", k), dut_out(),
                  {pc, vt[k].op, vt[k].rd, vt[k].rs1, vt[k].rs2,
                   vt[k].u1, vt[k].u2, vt[k].imm, vt[k].ill});
            cycle(1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
        end

        // Back-pressure: four offered with ready=0, only two are taken.
        pop_count = 0;
        for (int k = 0; k < 4; k++)
            cycle(1'b0, 32'h200 + 32'(k * 4), vt[k + 4].instr, 1'b0, 1'b0);
        check("bp_pops", 88'(pop_count), 88'd2);
        for (int k = 0; k < 2; k++)
            cycle(1'b0, 32'h210, vt[8].instr, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            cycle(1'b0, 32'h220 + 32'(k * 4), vt[k + 9].instr, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++)
            cycle(1'b1, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush while full with a non-empty queue.
        cycle(1'b0, 32'h300, vt[0].instr, 1'b0, 1'b0);
        cycle(1'b0, 32'h304, vt[1].instr, 1'b0, 1'b0);
        cycle(1'b0, 32'h308, vt[2].instr, 1'b1, 1'b1);
        check("clr_valid", 88'(bus.valid_to_reg), 88'd0);
        cycle(1'b0, 32'h30C, vt[13].instr, 1'b1, 1'b0);
        cycle(1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream while valid.
        cycle(1'b0, 32'h400, vt[5].instr, 1'b0, 1'b0);
        cycle(1'b0, 32'h404, vt[6].instr, 1'b0, 1'b0);
        check("pre_arst_valid", 88'(bus.valid_to_reg), 88'd1);
        bus.ready_from_dispatch = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 88'(bus.valid_to_reg), 88'd0);
        check("arst_pop", 88'(bus.pop_to_instr_queue), 88'd0);
        check("arst_out", dut_out(), 88'd0);
        @(negedge clk);
        exp_q.delete();
        rst = 1'b1;

        // Random traffic against the reference model.
        for (int k = 0; k < 400; k++)
            cycle($urandom_range(0, 3) == 0, $urandom, rand_instr(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
        for (int k = 0; k < 3; k++)
            cycle(1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
